// File: rtl/capture_ctrl.sv
// Capture controller: fills a circular sample RAM around a trigger event, then
// streams the captured window oldest-first over a valid/ready read port.
module capture_ctrl #(
  parameter int dsize = 32,
  parameter int aw    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [aw:0]      pre_count,
  input  logic [aw:0]      post_count,
  input  logic [dsize-1:0] dinput,
  input  logic             sample_en,
  output logic             trig_arm,
  output logic             trig_abort,
  input  logic             triggered,
  output logic [dsize-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_last,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [2:0]       dbg_state
);

  // Read port: a beat transfers on a cycle where rd_valid && rd_ready; while
  // rd_valid && !rd_ready, rd_data and rd_last hold until the beat is taken.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_ARM  = 3'd2,
    S_WAIT = 3'd3,
    S_POST = 3'd4,
    S_READ = 3'd5
  } state_t;

  localparam int D = 1 << aw;

  state_t state, state_n;

  logic [dsize-1:0] mem [D];
  logic [dsize-1:0] ram_q;
  logic [aw-1:0]    wr_ptr, trig_addr, rd_ptr, rd_addr, read_start;
  logic [aw:0]      cnt, pre_q, post_q, beats, rd_cnt, post_eff;
  logic [aw+1:0]    total;
  logic             cfg_ok, wr_en, trig_hit, enter_read, beat_acc, last_beat;

  assign post_eff   = (post_count == '0) ? (aw+1)'(1) : post_count;
  assign total      = {1'b0, pre_count} + {1'b0, post_eff};
  assign cfg_ok     = (total <= (aw+2)'(D));
  assign beats      = pre_q + post_q;
  assign last_beat  = (rd_cnt == beats - 1'b1);
  assign beat_acc   = rd_valid && rd_ready;
  assign rd_last    = rd_valid && last_beat;
  assign done       = beat_acc && last_beat;
  assign rd_data    = rd_valid ? ram_q : '0;
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;
  // Oldest sample of the window sits pre_q entries behind the trigger sample.
  assign read_start = ((state == S_WAIT) ? wr_ptr : trig_addr) - pre_q[aw-1:0];
  // Re-read the presented address while stalled so ram_q stays stable.
  assign rd_addr    = beat_acc ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    trig_arm   = 1'b0;
    trig_abort = 1'b0;
    wr_en      = 1'b0;
    trig_hit   = 1'b0;
    enter_read = 1'b0;
    case (state)
      S_IDLE: if (start && cfg_ok) state_n = (pre_count == '0) ? S_ARM : S_PRE;
      S_PRE: begin
        wr_en = sample_en;
        if (sample_en && (cnt + 1'b1 == pre_q)) state_n = S_ARM;
      end
      S_ARM: begin
        trig_arm = 1'b1;
        wr_en    = sample_en;
        state_n  = S_WAIT;
      end
      S_WAIT: begin
        wr_en = sample_en;
        if (triggered && sample_en) begin
          trig_hit = 1'b1;
          if (post_q == (aw+1)'(1)) begin
            state_n    = S_READ;
            enter_read = 1'b1;
          end else begin
            state_n = S_POST;
          end
        end
      end
      S_POST: begin
        wr_en = sample_en;
        if (sample_en && (cnt + 1'b1 == post_q)) begin
          state_n    = S_READ;
          enter_read = 1'b1;
        end
      end
      S_READ: if (done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (stop && (state inside {S_PRE, S_ARM, S_WAIT, S_POST})) begin
      trig_abort = 1'b1;
      state_n    = S_IDLE;
      wr_en      = 1'b0;
      trig_hit   = 1'b0;
      enter_read = 1'b0;
    end else if (stop && state == S_READ) begin
      state_n = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      cnt       <= '0;
      pre_q     <= '0;
      post_q    <= '0;
      trig_addr <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      rd_valid  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        if (cfg_ok) begin
          cfg_err <= 1'b0;
          pre_q   <= pre_count;
          post_q  <= post_eff;
          wr_ptr  <= '0;
          cnt     <= '0;
          rd_ptr  <= '0;
          rd_cnt  <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (wr_en && (state == S_PRE || state == S_POST)) cnt <= cnt + 1'b1;
      if (trig_hit) begin
        trig_addr <= wr_ptr;
        cnt       <= (aw+1)'(1);
      end
      if (enter_read) begin
        rd_ptr <= read_start;
        rd_cnt <= '0;
      end else if (beat_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
      end
      rd_valid <= (state == S_READ) && (state_n == S_READ);
    end
  end

  // Sample RAM: contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= dinput;
    ram_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a small ring (aw=3, D=8): config
// vectors, a table of capture scenarios, and hand sequences for stop/reset.
module tb_capture_ctrl;
  localparam int AW   = 3;
  localparam int DW   = 32;
  localparam int BASE = 32'h100;

  logic          clk = 1'b0;
  logic          reset, start, stop, sample_en, triggered, rd_ready;
  logic [AW:0]   pre_count, post_count;
  logic [DW-1:0] dinput, rd_data;
  logic          trig_arm, trig_abort, rd_valid, rd_last, busy, done, cfg_err;
  logic [2:0]    dbg_state;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];

  capture_ctrl #(.dsize(DW), .aw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .pre_count(pre_count), .post_count(post_count), .dinput(dinput),
    .sample_en(sample_en), .trig_arm(trig_arm), .trig_abort(trig_abort),
    .triggered(triggered), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .busy(busy), .done(done),
    .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       pre, post, trig_at;
    logic [3:0] rdy;
    bit       gappy, stop_rd;
    int       first, n;
  } cap_t;

  typedef struct {
    int pre, post;
    bit exp_err;
  } cfg_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; sample_en = 0; triggered = 0; rd_ready = 0; dinput = '0;
  endtask

  task automatic do_start(input int pre, input int post);
    @(negedge clk);
    idle_inputs();
    pre_count  = pre[AW:0];
    post_count = post[AW:0];
    start      = 1;
  endtask

  task automatic run_capture(input cap_t v);
    int idx, rc, arm_cnt, arm_idx, done_cnt, read_wait, c;
    bit stopped, prev_stall, en, finished, was_last;
    logic [DW-1:0] prev_data;
    exp_q.delete();
    for (int k = 0; k < v.n; k++) exp_q.push_back(BASE + v.first + k);
    do_start(v.pre, v.post);
    idx = 0; rc = 0; arm_cnt = 0; arm_idx = -1; done_cnt = 0; read_wait = 0;
    stopped = 0; prev_stall = 0; prev_data = '0; finished = 0;
    for (c = 0; c < 200 && !finished; c++) begin
      @(negedge clk);
      start     = 0;
      en        = v.gappy ? (c % 3 != 2) : 1'b1;
      sample_en = en;
      dinput    = BASE + idx;
      triggered = (idx >= v.trig_at);
      if (rd_valid) begin
        rd_ready = v.rdy[rc % 4];
        rc++;
      end else begin
        rd_ready = 0;
      end
      stop = v.stop_rd && rd_valid && !stopped;
      #1;
      if (trig_arm) begin arm_cnt++; arm_idx = idx; end
      if (done) done_cnt++;
      if (dbg_state == 3'd5 && !rd_valid) read_wait++;
      if (prev_stall) begin
        check("stall_valid", rd_valid, 1);
        check("stall_data", rd_data, prev_data);
      end
      if (stop) begin
        check("no_abort_in_read", trig_abort, 0);
        stopped = 1;
      end
      if (rd_valid) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          was_last = (exp_q.size() == 1);
          check("beat_data", rd_data, exp_q[0]);
          check("beat_last", rd_last, was_last);
          check("beat_done", done, rd_ready && was_last);
          if (rd_ready) void'(exp_q.pop_front());
        end
      end
      prev_stall = rd_valid && !rd_ready && !stop;
      prev_data  = rd_data;
      if (en) idx++;
      if (!busy && (done_cnt > 0 || stopped)) finished = 1;
    end
    check("capture_terminates", finished, 1);
    check("end_idle", busy, 0);
    check("end_rd_valid", rd_valid, 0);
    check("arm_count", arm_cnt, 1);
    check("arm_at_pre", arm_idx, v.pre);
    if (v.stop_rd) begin
      check("stop_rd_no_done", done_cnt, 0);
    end else begin
      check("beats_left", exp_q.size(), 0);
      check("done_count", done_cnt, 1);
      check("read_latency_le2", read_wait <= 2, 1);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  cap_t caps[8];
  cfg_t cfgs[6];

  initial begin
    int bad;
    //           pre post trig rdy     gap stop first n
    caps[0] = '{4, 4, 10, 4'b1111, 0, 0, 6,  8};  // basic window
    caps[1] = '{0, 0, 1,  4'b1111, 0, 0, 1,  1};  // single beat
    caps[2] = '{5, 3, 26, 4'b1111, 0, 0, 21, 8};  // read start wraps
    caps[3] = '{3, 2, 7,  4'b1001, 0, 0, 4,  5};  // 1,0,0,1 stalls
    caps[4] = '{2, 3, 6,  4'b1011, 1, 0, 4,  5};  // triggered while sample_en=0
    caps[5] = '{7, 0, 12, 4'b1111, 1, 0, 5,  8};  // full ring, post 0 -> 1
    caps[6] = '{1, 1, 3,  4'b0110, 0, 0, 2,  2};  // WAIT straight to READ
    caps[7] = '{2, 2, 4,  4'b0000, 0, 1, 2,  4};  // stop during READ
    cfgs[0] = '{8, 1, 1};
    cfgs[1] = '{4, 4, 0};
    cfgs[2] = '{8, 0, 1};
    cfgs[3] = '{5, 4, 1};
    cfgs[4] = '{7, 0, 0};
    cfgs[5] = '{0, 8, 0};

    // Clock/reset
    idle_inputs();
    pre_count = '0; post_count = '0;
    reset = 1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_trig_arm", trig_arm, 0);
    check("rst_trig_abort", trig_abort, 0);
    check("rst_state", dbg_state, 0);
    reset = 0;

    // Config acceptance table
    for (int i = 0; i < 6; i++) begin
      do_start(cfgs[i].pre, cfgs[i].post);
      @(negedge clk);
      start = 0;
      #1;
      check("cfg_err", cfg_err, cfgs[i].exp_err);
      check("cfg_busy", busy, !cfgs[i].exp_err);
      if (cfgs[i].exp_err) begin
        check("cfg_no_arm", trig_arm, 0);
        @(negedge clk);
        check("cfg_still_idle", busy, 0);
      end else begin
        stop = 1;
        #1;
        check("cfg_abort", trig_abort, 1);
        @(negedge clk);
        stop = 0;
        #1;
        check("cfg_abort_idle", busy, 0);
        check("cfg_abort_pulse", trig_abort, 0);
      end
    end

    // Capture scenarios
    for (int i = 0; i < 8; i++) run_capture(caps[i]);

    // Stop during WAIT
    do_start(2, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 0; sample_en = 1; dinput = BASE + k;
    end
    #1;
    check("wait_state", dbg_state, 3);
    stop = 1;
    #1;
    check("wait_abort", trig_abort, 1);
    @(negedge clk);
    stop = 0;
    #1;
    check("wait_abort_busy", busy, 0);
    check("wait_abort_pulse", trig_abort, 0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      triggered = 1;
      #1;
      if (rd_valid || done || busy) bad++;
    end
    check("wait_abort_quiet", bad, 0);
    idle_inputs();

    // Start and stop together in IDLE: start wins
    do_start(2, 2);
    stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    #1;
    check("start_beats_stop", busy, 1);

    // Reset mid-capture
    sample_en = 1;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    idle_inputs();
    #1;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_state", dbg_state, 0);
    check("mid_reset_rd_valid", rd_valid, 0);

    // Capture still works after reset
    run_capture(caps[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
